load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
In-order initiator for the data memory port. Accepts load/store ops from the issue stage via valid/ready and buffers them in a FIFO. Drives the memory's read/write/address/write-data strobes, one access per cycle, and returns tagged completions (load data or store-done) to the ROB/writeback stage. Misaligned and out-of-range addresses are trapped before reaching memory.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, ≥2)
TAG_W, 4, ROB tag width
MEM_BYTES, 256, byte-addressable memory size; valid word addresses are 0..MEM_BYTES-2

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  FIFO not full
in_store  in  1  1=store, 0=load
in_addr  in  16  byte address
in_wdata  in  16  store data
in_tag  in  TAG_W  ROB tag
flush  in  1  discard all pending ops
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  16  memory byte address
mem_wdata  out  16  store word, big-endian: [15:8]→addr, [7:0]→addr+1
mem_rdata  in  16  read word; memory updates it on negedge of the strobe cycle, valid at the next posedge
res_valid  out  1  completion present
res_ready  in  1  consumer accepts completion
res_tag  out  TAG_W  tag of completed op
res_data  out  16  load data; 0 for stores and exceptions
res_exc  out  1  1=misaligned or out-of-range access

Behaviour:
- Reset: FIFO empty, S1/S2 invalid. in_ready=1. mem_read=mem_write=0, mem_addr=mem_wdata=0. res_valid=0, res_tag=0, res_data=0, res_exc=0.
- FIFO: push on in_valid&in_ready; pop when S1 loads. Simultaneous push/pop when full is not allowed (in_ready=0 blocks push). Pointers wrap modulo DEPTH. Empty push lands at the head; no bypass into S1 in the same cycle.
- Stage S1 (access): loads the FIFO head when S1 is empty or S1 advances this cycle. A fresh bit is set on load.
- Exception check at S1 load: exc = addr[0] | (addr > MEM_BYTES-2).
- Strobes are combinational from S1: mem_read = S1.valid & fresh & ~store & ~exc; mem_write = S1.valid & fresh & store & ~exc. mem_addr and mem_wdata follow S1 whenever S1 is valid, else 0. Each access strobes exactly one cycle; fresh clears at the next posedge, so a stalled store is never re-written.
- S1→S2 transfer when S1.valid & (~S2.valid | res_ready):
  - res_data = fresh&load&~exc ? mem_rdata : held S1 data.
  - If S1 is fresh, is a load and cannot advance, it captures mem_rdata into its held-data field at the same posedge.
  - Stores and exceptions give res_data=0.
- S2 holds res_* stable while res_valid & ~res_ready.
- Latency: request accepted at edge E0 → S1 at E1 (strobe during E1..E2) → res_valid from E2. Throughput is 1 op/cycle with res_ready=1.
- Ordering: strictly in order. No forwarding is needed because only one access is outstanding at the memory.
- Flush: at that posedge, FIFO emptied and S1/S2 invalidated, fresh cleared. A strobe asserted in the flush cycle still completes at memory; its result is dropped. Flush has priority over same-cycle push.
- Reset mid-operation: all state returns to reset values at the next posedge. Any in-flight strobe is abandoned.

Decomposition:
- Shared package: op-entry struct {store, addr, wdata, tag, exc}, MEM_BYTES constant, the EXC encoding.
- One sub-module: lsu_req_fifo (parameterised DEPTH synchronous FIFO with flush).
- S1/S2 pipeline and strobe logic stay in load_store_unit.

Test Plan:
- Load tag 3 addr 100 (memory preset to 0x9C40), res_ready=1 → mem_read high for exactly 1 cycle at E1 with mem_addr=100; res_valid at E2, res_tag=3, res_data=0x9C40, res_exc=0.
- Store addr 120 data 0x1234 tag 1, then load addr 120 tag 2 → single mem_write cycle with mem_wdata=0x1234; load returns 0x1234; completions in order tag1 then tag2.
- Load addr 101 tag 5 → no strobe; res_exc=1, res_data=0, tag 5. Load addr 0x0100 → res_exc=1.
- Push 6 ops back-to-back with res_ready=0 → in_ready drops after FIFO+S1+S2 fill (DEPTH+2 = 6 occupancy); exactly one strobe per op; release res_ready → 6 ordered completions, one per cycle.
- Store held in S1 while res_ready=0 for 4 cycles → mem_write asserted only in the first cycle.
- Flush with 3 ops queued and one in S2 → res_valid=0 and in_ready=1 next cycle; no further strobes; a new load of addr 102 returns 0x7530.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit:
//   - LSU_MEM_BYTES : size of the byte-addressable data memory
//   - LSU_TAG_W     : width of the ROB tag carried in an op entry
//   - EXC_NONE/EXC_FAULT : encoding of the access-exception flag
//   - op_entry_t    : one buffered load/store request
//   - addr_exc()    : misaligned / out-of-range address check
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam int LSU_MEM_BYTES = 256;
    localparam int LSU_TAG_W     = 4;

    localparam logic EXC_NONE  = 1'b0;
    localparam logic EXC_FAULT = 1'b1;

    typedef struct packed {
        logic                 store;
        logic [15:0]          addr;
        logic [15:0]          wdata;
        logic [LSU_TAG_W-1:0] tag;
        logic                 exc;
    } op_entry_t;

    // A word access touches addr and addr+1, so the last legal word address
    // is (memory size - 2); odd addresses are misaligned.
    function automatic logic addr_exc(input logic [15:0] addr,
                                      input logic [15:0] last_word);
        return (addr[0] || (addr > last_word)) ? EXC_FAULT : EXC_NONE;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the three LSU-facing channels:
//   issue  : in_valid/in_ready/in_store/in_addr/in_wdata/in_tag, flush
//   memory : mem_read/mem_write/mem_addr/mem_wdata, mem_rdata
//   result : res_valid/res_ready/res_tag/res_data/res_exc
// master : the LSU view (drives in_ready, memory strobes and results)
// slave  : the environment view (issue stage, memory and ROB/writeback)
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_store;
    logic [15:0]      in_addr;
    logic [15:0]      in_wdata;
    logic [TAG_W-1:0] in_tag;
    logic             flush;

    logic             mem_read;
    logic             mem_write;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_wdata;
    logic [15:0]      mem_rdata;

    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_tag;
    logic [15:0]      res_data;
    logic             res_exc;

    modport master (
        input  in_valid, in_store, in_addr, in_wdata, in_tag, flush,
        input  mem_rdata, res_ready,
        output in_ready, mem_read, mem_write, mem_addr, mem_wdata,
        output res_valid, res_tag, res_data, res_exc
    );

    modport slave (
        output in_valid, in_store, in_addr, in_wdata, in_tag, flush,
        output mem_rdata, res_ready,
        input  in_ready, mem_read, mem_write, mem_addr, mem_wdata,
        input  res_valid, res_tag, res_data, res_exc
    );
endinterface

// File: rtl/load_store_unit_req_fifo.sv
// -----------------------------------------------------------------------------
// lsu_req_fifo
// Synchronous DEPTH-entry request FIFO with flush.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO at the next posedge (beats push/pop)
//   push, push_data : write request (ignored when full)
//   pop        : advance head (ignored when empty)
//   head       : current head entry (valid when !empty)
//   empty, full: occupancy flags
// -----------------------------------------------------------------------------
module lsu_req_fifo
    import load_store_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  op_entry_t push_data,
    input  logic      pop,
    output op_entry_t head,
    output logic      empty,
    output logic      full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    op_entry_t        mem_q [DEPTH];
    op_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;  // DEPTH is a power of 2: natural wrap
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// In-order initiator for the data memory port. Requests from the issue stage
// are queued in lsu_req_fifo, then flow through:
//   S1 (access)  : drives one memory strobe per op, traps bad addresses
//   S2 (result)  : registered tagged completion toward ROB/writeback
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : load_store_unit_if.master (issue, memory and result channels)
// The tag field width comes from the package (LSU_TAG_W); TAG_W must match it.
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = LSU_TAG_W,
    parameter int MEM_BYTES = LSU_MEM_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.master bus
);
    localparam logic [15:0] LAST_WORD = 16'(MEM_BYTES - 2);

    op_entry_t push_entry, head_entry;
    logic      fifo_empty, fifo_full;
    logic      s1_adv, s1_load, s1_rd_hit;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_fresh_q, s1_fresh_d;
    op_entry_t        s1_op_q,    s1_op_d;
    logic [15:0]      s1_data_q,  s1_data_d;

    logic             s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
    logic [15:0]      s2_data_q,  s2_data_d;
    logic             s2_exc_q,   s2_exc_d;

    always_comb begin
        push_entry       = '0;
        push_entry.store = bus.in_store;
        push_entry.addr  = bus.in_addr;
        push_entry.wdata = bus.in_wdata;
        push_entry.tag   = bus.in_tag;
        push_entry.exc   = EXC_NONE;
    end

    lsu_req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .push      (bus.in_valid),
        .push_data (push_entry),
        .pop       (s1_load),
        .head      (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign s1_adv    = s1_valid_q & (~s2_valid_q | bus.res_ready);
    assign s1_load   = ~fifo_empty & (~s1_valid_q | s1_adv);
    // Only the first S1 cycle of a good load has read data arriving.
    assign s1_rd_hit = s1_valid_q & s1_fresh_q & ~s1_op_q.store & ~s1_op_q.exc;

    assign bus.in_ready  = ~fifo_full;
    assign bus.mem_read  = s1_rd_hit;
    assign bus.mem_write = s1_valid_q & s1_fresh_q & s1_op_q.store & ~s1_op_q.exc;
    assign bus.mem_addr  = s1_valid_q ? s1_op_q.addr  : 16'h0000;
    assign bus.mem_wdata = s1_valid_q ? s1_op_q.wdata : 16'h0000;

    assign bus.res_valid = s2_valid_q;
    assign bus.res_tag   = s2_tag_q;
    assign bus.res_data  = s2_data_q;
    assign bus.res_exc   = s2_exc_q;

    // ---- S1: access stage ----
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_fresh_d = 1'b0;
        s1_op_d    = s1_op_q;
        s1_data_d  = s1_data_q;
        if (bus.flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_load) begin
            s1_valid_d  = 1'b1;
            s1_fresh_d  = 1'b1;
            s1_op_d     = head_entry;
            s1_op_d.exc = addr_exc(head_entry.addr, LAST_WORD);
            s1_data_d   = 16'h0000;   // stores and exceptions report zero
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end else if (s1_rd_hit) begin
            // Stalled load: read data is only valid this edge, keep a copy.
            s1_data_d = bus.mem_rdata;
        end
    end

    // ---- S2: result stage ----
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_tag_d   = s2_tag_q;
        s2_data_d  = s2_data_q;
        s2_exc_d   = s2_exc_q;
        if (bus.flush) begin
            s2_valid_d = 1'b0;
        end else if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_tag_d   = s1_op_q.tag;
            s2_data_d  = s1_rd_hit ? bus.mem_rdata : s1_data_q;
            s2_exc_d   = s1_op_q.exc;
        end else if (bus.res_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_fresh_q <= 1'b0;
            s1_op_q    <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            s2_data_q  <= '0;
            s2_exc_q   <= EXC_NONE;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_fresh_q <= s1_fresh_d;
            s1_op_q    <= s1_op_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            s2_data_q  <= s2_data_d;
            s2_exc_q   <= s2_exc_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit: byte-array memory model answering the
// strobes on negedge, completion monitor, vector table plus hand sequences
// for timing, back-pressure and flush.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.TAG_W(4)) bus ();

    load_store_unit #(.DEPTH(4), .TAG_W(4), .MEM_BYTES(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [15:0] data;
        logic        exc;
        int          cyc;
    } cmp_t;

    typedef struct {
        logic        store;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  tag;
        logic [15:0] exp_data;
        logic        exp_exc;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    logic [7:0] mem [0:255];
    cmp_t       cq[$];
    int         cyc = 0;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         n_pass = 0;
    int         n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acts on the negedge of the strobe cycle.
    always @(negedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr[7:0]]        <= bus.mem_wdata[15:8];
            mem[bus.mem_addr[7:0] + 8'd1] <= bus.mem_wdata[7:0];
        end
        if (bus.mem_read)
            bus.mem_rdata <= {mem[bus.mem_addr[7:0]], mem[bus.mem_addr[7:0] + 8'd1]};
    end

    // Strobe counters and completion capture.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_read)  rd_cnt <= rd_cnt + 1;
            if (bus.mem_write) wr_cnt <= wr_cnt + 1;
            if (bus.res_valid && bus.res_ready)
                cq.push_back('{tag: bus.res_tag, data: bus.res_data, exc: bus.res_exc, cyc: cyc});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic send_op(input logic st, input logic [15:0] a, input logic [15:0] wd,
                           input logic [3:0] t);
        int  k;
        logic ok;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_store = st; bus.in_addr = a;
        bus.in_wdata = wd;   bus.in_tag = t;
        k = 0;
        do begin
            @(negedge clk); ok = bus.in_ready;
            @(posedge clk); k++;
        end while (!ok && k < 40);
        #1 bus.in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'(k), 32'd0);
    endtask

    task automatic wait_cmp(input int n);
        int k = 0;
        while (cq.size() < n && k < 40) begin
            @(posedge clk); k++;
        end
        @(negedge clk);
        chk("cmp_count", 32'(cq.size()), 32'(n));
    endtask

    vec_t vecs [10];
    int   rd0, wr0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[100] = 8'h9C; mem[101] = 8'h40;
        mem[102] = 8'h75; mem[103] = 8'h30;
        mem[254] = 8'hBE; mem[255] = 8'hEF;
        bus.mem_rdata = 16'h0000;
        bus.in_valid = 1'b0; bus.in_store = 1'b0; bus.in_addr = '0;
        bus.in_wdata = '0;   bus.in_tag = '0;     bus.flush = 1'b0;
        bus.res_ready = 1'b1;

        vecs[0] = '{1'b1, 16'd120,   16'h1234, 4'd1,  16'h0000, 1'b0, 0, 1};
        vecs[1] = '{1'b0, 16'd120,   16'h0000, 4'd2,  16'h1234, 1'b0, 1, 0};
        vecs[2] = '{1'b0, 16'd101,   16'h0000, 4'd5,  16'h0000, 1'b1, 0, 0};
        vecs[3] = '{1'b0, 16'h0100,  16'h0000, 4'd6,  16'h0000, 1'b1, 0, 0};
        vecs[4] = '{1'b0, 16'd254,   16'h0000, 4'd7,  16'hBEEF, 1'b0, 1, 0};
        vecs[5] = '{1'b1, 16'd255,   16'hFFFF, 4'd8,  16'h0000, 1'b1, 0, 0};
        vecs[6] = '{1'b1, 16'd256,   16'h5555, 4'd9,  16'h0000, 1'b1, 0, 0};
        vecs[7] = '{1'b1, 16'd0,     16'hA5C3, 4'd10, 16'h0000, 1'b0, 0, 1};
        vecs[8] = '{1'b0, 16'd0,     16'h0000, 4'd11, 16'hA5C3, 1'b0, 1, 0};
        vecs[9] = '{1'b0, 16'd102,   16'h0000, 4'd12, 16'h7530, 1'b0, 1, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_tag",   32'(bus.res_tag),   32'd0);
        chk("rst_res_data",  32'(bus.res_data),  32'd0);
        chk("rst_res_exc",   32'(bus.res_exc),   32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Load latency: accept at E0, strobe E1..E2, result from E2
        rd0 = rd_cnt;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_store = 1'b0; bus.in_addr = 16'd100; bus.in_tag = 4'd3;
        @(posedge clk); #1 bus.in_valid = 1'b0;          // E0
        @(negedge clk);
        chk("lat_e0_mem_read", 32'(bus.mem_read), 32'd0);
        @(negedge clk);
        chk("lat_e1_mem_read", 32'(bus.mem_read), 32'd1);
        chk("lat_e1_mem_addr", 32'(bus.mem_addr), 32'd100);
        chk("lat_e1_res_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk("lat_e2_mem_read", 32'(bus.mem_read), 32'd0);
        chk("lat_e2_res_valid", 32'(bus.res_valid), 32'd1);
        chk("lat_e2_res_tag",  32'(bus.res_tag),  32'd3);
        chk("lat_e2_res_data", 32'(bus.res_data), 32'h9C40);
        chk("lat_e2_res_exc",  32'(bus.res_exc),  32'd0);
        chk("lat_rd_count", 32'(rd_cnt - rd0), 32'd1);

        // Single-op vector table
        for (int v = 0; v < 10; v++) begin
            @(posedge clk);
            cq.delete();
            rd0 = rd_cnt; wr0 = wr_cnt;
            send_op(vecs[v].store, vecs[v].addr, vecs[v].wdata, vecs[v].tag);
            wait_cmp(1);
            repeat (2) @(posedge clk);
            @(negedge clk);
            if (cq.size() > 0) begin
                chk($sformatf("vec%0d_tag", v),  32'(cq[0].tag),  32'(vecs[v].tag));
                chk($sformatf("vec%0d_data", v), 32'(cq[0].data), 32'(vecs[v].exp_data));
                chk($sformatf("vec%0d_exc", v),  32'(cq[0].exc),  32'(vecs[v].exp_exc));
            end
            chk($sformatf("vec%0d_rd", v), 32'(rd_cnt - rd0), 32'(vecs[v].exp_rd));
            chk($sformatf("vec%0d_wr", v), 32'(wr_cnt - wr0), 32'(vecs[v].exp_wr));
        end

        // Back-pressure burst: 3 stores then 3 loads of the same words
        @(posedge clk); #1 bus.res_ready = 1'b0;
        cq.delete();
        rd0 = rd_cnt; wr0 = wr_cnt;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_store = (i < 3);
            bus.in_addr  = 16'(200 + 2 * (i % 3));
            bus.in_wdata = 16'(16'h1100 + (i % 3));
            bus.in_tag   = 4'(i + 1);
            @(negedge clk);
            chk($sformatf("burst_in_ready%0d", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("burst_full_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_strobe%0d", i), 32'({bus.mem_read, bus.mem_write}), 32'd0);
            @(negedge clk);
        end
        chk("stall_wr_count", 32'(wr_cnt - wr0), 32'd2);
        chk("stall_rd_count", 32'(rd_cnt - rd0), 32'd0);
        chk("stall_no_cmp", 32'(cq.size()), 32'd0);
        @(posedge clk); #1 bus.res_ready = 1'b1;
        wait_cmp(6);
        for (int i = 0; i < 6; i++) begin
            if (cq.size() > i) begin
                chk($sformatf("burst%0d_tag", i),  32'(cq[i].tag), 32'(i + 1));
                chk($sformatf("burst%0d_data", i), 32'(cq[i].data),
                    (i < 3) ? 32'd0 : 32'(16'h1100 + (i - 3)));
                chk($sformatf("burst%0d_exc", i),  32'(cq[i].exc), 32'd0);
                if (i > 0)
                    chk($sformatf("burst%0d_gap", i), 32'(cq[i].cyc - cq[i-1].cyc), 32'd1);
            end
        end
        chk("burst_wr_total", 32'(wr_cnt - wr0), 32'd3);
        chk("burst_rd_total", 32'(rd_cnt - rd0), 32'd3);

        // Flush with ops in S2, S1 and the FIFO; same-cycle push is dropped
        @(posedge clk); #1 bus.res_ready = 1'b0;
        cq.delete();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_store = 1'b0;
            bus.in_addr = 16'd100; bus.in_tag = 4'(i + 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_store = 1'b0; bus.in_addr = 16'd100; bus.in_tag = 4'd15;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.res_ready = 1'b1;
        rd0 = rd_cnt;
        @(negedge clk);
        chk("flush_res_valid", 32'(bus.res_valid), 32'd0);
        chk("flush_in_ready",  32'(bus.in_ready),  32'd1);
        chk("flush_mem_read",  32'(bus.mem_read),  32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("flush_no_strobe", 32'(rd_cnt - rd0), 32'd0);
        chk("flush_no_cmp", 32'(cq.size()), 32'd0);
        send_op(1'b0, 16'd102, 16'h0000, 4'd4);
        wait_cmp(1);
        if (cq.size() > 0) begin
            chk("post_flush_tag",  32'(cq[0].tag),  32'd4);
            chk("post_flush_data", 32'(cq[0].data), 32'h7530);
            chk("post_flush_exc",  32'(cq[0].exc),  32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
